// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin share of one pipelined multiplier with in-order result steering
module mul_share_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = 3,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_rs1,
  input  logic [NUM_REQ*32-1:0]   req_rs2,
  input  logic [NUM_REQ*2-1:0]    req_op,
  input  logic [NUM_REQ*ID_W-1:0] req_id,
  output logic [31:0]             mul_rs1,
  output logic [31:0]             mul_rs2,
  output logic [1:0]              mul_op,
  output logic [ID_W-1:0]         mul_id,
  output logic                    mul_new_request,
  input  logic                    mul_ready,
  input  logic                    mul_done,
  input  logic [ID_W-1:0]         mul_wb_id,
  input  logic [31:0]             mul_rd,
  output logic                    mul_ack,
  output logic [NUM_REQ-1:0]      wb_done,
  output logic [ID_W-1:0]         wb_id,
  output logic [31:0]             wb_rd,
  input  logic [NUM_REQ-1:0]      wb_ack
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int AW    = $clog2(TAG_DEPTH);
  localparam int CW    = AW + 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_tag [TAG_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [NUM_REQ-1:0] w_rot;
  logic               w_any;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_gnt;
  logic [PTR_W-1:0]   w_gnt_nxt;
  logic [PTR_W-1:0]   w_owner;
  logic               w_tag_empty;
  logic               w_tag_full;
  logic               w_res_valid;
  logic               w_pop;
  logic               w_issue;

  // bit 0 of the rotated vector is the requester currently holding top priority
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

  // find the first pending request at or after rr_ptr and map it back to an absolute index
  always_comb begin
    w_any = 1'b0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      end
    end
    if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
    end
    w_gnt = w_sum[PTR_W-1:0];
  end

  assign w_gnt_nxt = (w_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

  assign w_tag_empty = (r_count == '0);
  assign w_tag_full  = (r_count == CW'(TAG_DEPTH));
  assign w_owner     = r_tag[r_rd_ptr];
  assign w_res_valid = mul_done & ~w_tag_empty;

  // steer the in-order result to whoever issued the oldest outstanding op
  always_comb begin
    wb_done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb_done[i] = w_res_valid && (w_owner == PTR_W'(i));
    end
  end

  assign mul_ack = |(wb_done & wb_ack);
  assign w_pop   = mul_ack;
  assign wb_id   = mul_wb_id;
  assign wb_rd   = mul_rd;

  // a full FIFO may still accept when its head leaves in the same cycle; nothing issues in reset
  assign w_issue         = rst_n & w_any & mul_ready & ~(w_tag_full & ~w_pop);
  assign mul_new_request = w_issue;

  // operand mux tracks the selected requester regardless of whether it issues
  always_comb begin
    req_ready = '0;
    mul_rs1   = '0;
    mul_rs2   = '0;
    mul_op    = '0;
    mul_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_any && (w_gnt == PTR_W'(i))) begin
        mul_rs1      = req_rs1[i*32 +: 32];
        mul_rs2      = req_rs2[i*32 +: 32];
        mul_op       = req_op[i*2 +: 2];
        mul_id       = req_id[i*ID_W +: ID_W];
        req_ready[i] = w_issue;
      end
    end
  end

  // priority pointer and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        r_rr_ptr <= w_gnt_nxt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // owner tag storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_tag[r_wr_ptr] <= w_gnt;
    end
  end

  // a result with no recorded owner means the multiplier and this FIFO are out of step
  a_owned_result: assert property (@(posedge clk) disable iff (!rst_n) !(mul_done && w_tag_empty));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [3:0]  req_op;
  logic [5:0]  req_id;
  logic [31:0] mul_rs1;
  logic [31:0] mul_rs2;
  logic [1:0]  mul_op;
  logic [2:0]  mul_id;
  logic        mul_new_request;
  logic        mul_ready;
  logic        mul_done;
  logic [2:0]  mul_wb_id;
  logic [31:0] mul_rd;
  logic        mul_ack;
  logic [1:0]  wb_done;
  logic [2:0]  wb_id;
  logic [31:0] wb_rd;
  logic [1:0]  wb_ack;

  int n_total = 0;
  int n_bad   = 0;

  mul_share_arbiter #(.NUM_REQ(2), .ID_W(3), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op), .req_id(req_id),
    .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_op(mul_op), .mul_id(mul_id),
    .mul_new_request(mul_new_request), .mul_ready(mul_ready),
    .mul_done(mul_done), .mul_wb_id(mul_wb_id), .mul_rd(mul_rd), .mul_ack(mul_ack),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] drain_owner [4];
    drain_owner[0] = 2'b10;
    drain_owner[1] = 2'b01;
    drain_owner[2] = 2'b10;
    drain_owner[3] = 2'b01;

    // req0: 3*5 MUL id1, req1: 0xFFFFFFFF*2 MULHU id2
    req_rs1   = {32'hFFFF_FFFF, 32'd3};
    req_rs2   = {32'd2, 32'd5};
    req_op    = {2'd3, 2'd0};
    req_id    = {3'd2, 3'd1};
    rst_n     = 1'b0;
    req_valid = 2'b11;
    mul_ready = 1'b1;
    mul_done  = 1'b0;
    mul_wb_id = 3'd0;
    mul_rd    = 32'd0;
    wb_ack    = 2'b11;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_new_req", mul_new_request, 1'b0);
    chk("rst_wb_done", wb_done, 2'b00);
    chk("rst_mul_ack", mul_ack, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // fairness: grants alternate 0,1,0,1 and results come back in the same order
    chk("rr0_ready", req_ready, 2'b01);
    chk("rr0_new", mul_new_request, 1'b1);
    chk("rr0_rs1", mul_rs1, 32'd3);
    chk("rr0_rs2", mul_rs2, 32'd5);
    chk("rr0_op", mul_op, 2'd0);
    chk("rr0_id", mul_id, 3'd1);
    tick();
    chk("rr1_ready", req_ready, 2'b10);
    chk("rr1_rs1", mul_rs1, 32'hFFFF_FFFF);
    chk("rr1_op", mul_op, 2'd3);
    chk("rr1_id", mul_id, 3'd2);
    tick();
    mul_done = 1'b1; mul_wb_id = 3'd1; mul_rd = 32'd15;
    #1;
    chk("rr2_ready", req_ready, 2'b01);
    chk("res0_done", wb_done, 2'b01);
    chk("res0_rd", wb_rd, 32'd15);
    chk("res0_id", wb_id, 3'd1);
    chk("res0_ack", mul_ack, 1'b1);
    tick();
    mul_wb_id = 3'd2; mul_rd = 32'd1;
    #1;
    chk("rr3_ready", req_ready, 2'b10);
    chk("res1_done", wb_done, 2'b10);
    chk("res1_rd", wb_rd, 32'd1);
    tick();
    req_valid = 2'b00; mul_wb_id = 3'd1; mul_rd = 32'd15;
    #1;
    chk("idle_ready", req_ready, 2'b00);
    chk("idle_rs1_zero", mul_rs1, 32'd0);
    chk("idle_id_zero", mul_id, 3'd0);
    chk("res2_done", wb_done, 2'b01);
    tick();
    mul_wb_id = 3'd2; mul_rd = 32'd1;
    #1;
    chk("res3_done", wb_done, 2'b10);
    tick();
    mul_done = 1'b0;

    // single requester at rr_ptr=0, then a writeback stall on its result
    req_valid = 2'b10;
    #1;
    chk("single_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    mul_done = 1'b1; mul_wb_id = 3'd2; mul_rd = 32'd1;
    wb_ack = 2'b01; mul_ready = 1'b0; req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stall%0d_done", c), wb_done, 2'b10);
      chk($sformatf("stall%0d_ack", c), mul_ack, 1'b0);
      chk($sformatf("stall%0d_ready", c), req_ready, 2'b00);
      tick();
    end
    wb_ack = 2'b11;
    #1;
    chk("stall_rel_done", wb_done, 2'b10);
    chk("stall_rel_ack", mul_ack, 1'b1);
    tick();
    mul_done = 1'b0; mul_ready = 1'b1;
    #1;
    chk("wrap_ready", req_ready, 2'b01);
    tick();

    // fill the FIFO: owners 0,1,0,1
    chk("fill1_ready", req_ready, 2'b10);
    tick();
    chk("fill2_ready", req_ready, 2'b01);
    tick();
    chk("fill3_ready", req_ready, 2'b10);
    tick();
    chk("full_ready", req_ready, 2'b00);
    chk("full_new", mul_new_request, 1'b0);
    tick();
    mul_done = 1'b1; mul_wb_id = 3'd1; mul_rd = 32'd15;
    #1;
    chk("fullpop_done", wb_done, 2'b01);
    chk("fullpop_ack", mul_ack, 1'b1);
    chk("fullpop_ready", req_ready, 2'b01);
    tick();
    mul_done = 1'b0;
    #1;
    chk("still_full_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b00; mul_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("drain%0d_done", c), wb_done, drain_owner[c]);
      tick();
    end
    mul_done = 1'b0;

    // reset with two req1 ops in flight
    req_valid = 2'b10;
    #1;
    chk("mf0_ready", req_ready, 2'b10);
    tick();
    chk("mf1_ready", req_ready, 2'b10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mfrst_ready", req_ready, 2'b00);
    chk("mfrst_new", mul_new_request, 1'b0);
    chk("mfrst_done", wb_done, 2'b00);
    chk("mfrst_ack", mul_ack, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", wb_done, 2'b00);
    req_valid = 2'b01;
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    mul_done = 1'b1; mul_wb_id = 3'd1; mul_rd = 32'd15;
    #1;
    chk("post_rst_owner", wb_done, 2'b01);
    tick();
    mul_done = 1'b0;
    #1;
    chk("post_rst_idle", wb_done, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
